// File: rtl/jtag_tap_ctrl_if.sv
// TAP-side and boundary-scan-side signals of jtag_tap_ctrl, bundled into one interface.
interface jtag_tap_ctrl_if #(
    parameter int unsigned IR_WIDTH = 4
);
    logic                tck_en;
    logic                tms;
    logic                tdi;
    logic                bsr_so;
    logic                tdo;
    logic                tdo_en;
    logic                bsr_si;
    logic                shift_dr;
    logic                capture_en;
    logic                update_en;
    logic                mode;
    logic [3:0]          tap_state;
    logic [IR_WIDTH-1:0] ir_q;

    // Test driver / TAP master side
    modport master (
        output tck_en, tms, tdi, bsr_so,
        input  tdo, tdo_en, bsr_si, shift_dr, capture_en, update_en, mode, tap_state, ir_q
    );

    // TAP controller side
    modport slave (
        input  tck_en, tms, tdi, bsr_so,
        output tdo, tdo_en, bsr_si, shift_dr, capture_en, update_en, mode, tap_state, ir_q
    );
endinterface

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller: 16-state FSM, IR, bypass and IDCODE registers,
// plus control strobes for a downstream boundary-scan cell chain.
module jtag_tap_ctrl #(
    parameter int unsigned         IR_WIDTH  = 4,
    parameter logic [IR_WIDTH-1:0] OP_EXTEST = IR_WIDTH'(0),
    parameter logic [IR_WIDTH-1:0] OP_SAMPLE = IR_WIDTH'(1),
    parameter logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(2),
    parameter logic [31:0]         ID_VALUE  = 32'h1000_0ADB
) (
    input  logic            clk,
    input  logic            rst,
    jtag_tap_ctrl_if.slave  tap
);

    localparam int unsigned ID_WIDTH = 32;

    typedef enum logic [3:0] {
        TLR      = 4'hF,
        RTI      = 4'hC,
        SEL_DR   = 4'h7,
        CAP_DR   = 4'h6,
        SH_DR    = 4'h2,
        EX1_DR   = 4'h1,
        PAUSE_DR = 4'h3,
        EX2_DR   = 4'h0,
        UPD_DR   = 4'h5,
        SEL_IR   = 4'h4,
        CAP_IR   = 4'hE,
        SH_IR    = 4'hA,
        EX1_IR   = 4'h9,
        PAUSE_IR = 4'hB,
        EX2_IR   = 4'h8,
        UPD_IR   = 4'hD
    } tap_state_e;

    tap_state_e          state_q;
    logic [IR_WIDTH-1:0] ir_upd_q;
    logic [IR_WIDTH-1:0] ir_sr_q;
    logic                byp_q;
    logic [ID_WIDTH-1:0] id_sr_q;

    logic sel_bsr_c;
    logic sel_id_c;
    logic tdo_c;

    // TAP state machine, advancing only on TCK-edge qualifier cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= TLR;
        end else if (tap.tck_en) begin
            case (state_q)
                TLR:      state_q <= tap.tms ? TLR    : RTI;
                RTI:      state_q <= tap.tms ? SEL_DR : RTI;
                SEL_DR:   state_q <= tap.tms ? SEL_IR : CAP_DR;
                CAP_DR:   state_q <= tap.tms ? EX1_DR : SH_DR;
                SH_DR:    state_q <= tap.tms ? EX1_DR : SH_DR;
                EX1_DR:   state_q <= tap.tms ? UPD_DR : PAUSE_DR;
                PAUSE_DR: state_q <= tap.tms ? EX2_DR : PAUSE_DR;
                EX2_DR:   state_q <= tap.tms ? UPD_DR : SH_DR;
                UPD_DR:   state_q <= tap.tms ? SEL_DR : RTI;
                SEL_IR:   state_q <= tap.tms ? TLR    : CAP_IR;
                CAP_IR:   state_q <= tap.tms ? EX1_IR : SH_IR;
                SH_IR:    state_q <= tap.tms ? EX1_IR : SH_IR;
                EX1_IR:   state_q <= tap.tms ? UPD_IR : PAUSE_IR;
                PAUSE_IR: state_q <= tap.tms ? EX2_IR : PAUSE_IR;
                EX2_IR:   state_q <= tap.tms ? UPD_IR : SH_IR;
                UPD_IR:   state_q <= tap.tms ? SEL_DR : RTI;
                default:  state_q <= TLR;
            endcase
        end
    end

    // Instruction, bypass and IDCODE registers; capture/shift/update by TAP state
    always_ff @(posedge clk) begin
        if (rst) begin
            ir_upd_q <= OP_IDCODE;
            ir_sr_q  <= '0;
            byp_q    <= 1'b0;
            id_sr_q  <= ID_VALUE;
        end else if (tap.tck_en) begin
            case (state_q)
                TLR:    ir_upd_q <= OP_IDCODE;
                CAP_IR: ir_sr_q  <= IR_WIDTH'(2'b01);
                SH_IR:  ir_sr_q  <= {tap.tdi, ir_sr_q[IR_WIDTH-1:1]};
                UPD_IR: ir_upd_q <= ir_sr_q;
                CAP_DR: begin
                    byp_q   <= 1'b0;
                    id_sr_q <= ID_VALUE;
                end
                SH_DR: begin
                    if (sel_id_c) begin
                        id_sr_q <= {tap.tdi, id_sr_q[ID_WIDTH-1:1]};
                    end
                    if (!sel_id_c && !sel_bsr_c) begin
                        byp_q <= tap.tdi;
                    end
                end
                default: ;
            endcase
        end
    end

    // Data-register selection from the active instruction; unknown opcodes fall to bypass
    always_comb begin
        sel_bsr_c = (ir_upd_q == OP_EXTEST) || (ir_upd_q == OP_SAMPLE);
        sel_id_c  = !sel_bsr_c && (ir_upd_q == OP_IDCODE);
    end

    // TDO mux: only meaningful in the two shift states, quiet elsewhere
    always_comb begin
        tdo_c = 1'b0;
        case (state_q)
            SH_IR: tdo_c = ir_sr_q[0];
            SH_DR: begin
                if (sel_bsr_c) begin
                    tdo_c = tap.bsr_so;
                end else if (sel_id_c) begin
                    tdo_c = id_sr_q[0];
                end else begin
                    tdo_c = byp_q;
                end
            end
            default: tdo_c = 1'b0;
        endcase
    end

    assign tap.tdo        = tdo_c;
    assign tap.tdo_en     = (state_q == SH_IR) || (state_q == SH_DR);
    assign tap.bsr_si     = tap.tdi;
    assign tap.shift_dr   = sel_bsr_c && (state_q == SH_DR);
    assign tap.capture_en = sel_bsr_c && tap.tck_en && (state_q == CAP_DR);
    assign tap.update_en  = sel_bsr_c && tap.tck_en && (state_q == UPD_DR);
    assign tap.mode       = (ir_upd_q == OP_EXTEST);
    assign tap.tap_state  = state_q;
    assign tap.ir_q       = ir_upd_q;

endmodule

// File: doc/jtag_tap_ctrl.md
Name: jtag_tap_ctrl

Overview:
- IEEE 1149.1 TAP controller that drives the DW_bc_10 boundary-scan cell chain directly downstream of it.
- Contains the 16-state TAP FSM, an instruction register, a bypass register and an IDCODE register.
- Produces the shift, capture, update and mode controls for the boundary-scan register (BSR), and muxes TDO.
- Single system clock; TCK edges arrive as the qualifier `tck_en`.

Parameters:
- IR_WIDTH, 4, instruction register width (≥2).
- OP_EXTEST, 4'b0000, EXTEST opcode.
- OP_SAMPLE, 4'b0001, SAMPLE/PRELOAD opcode.
- OP_IDCODE, 4'b0010, IDCODE opcode.
- ID_VALUE, 32'h1000_0ADB, IDCODE register contents (bit0 must be 1).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- tck_en  in  1  one-cycle TCK-edge qualifier; the FSM and all scan registers advance only when it is 1.
- tms  in  1  test mode select, sampled when tck_en=1.
- tdi  in  1  test data in, sampled when tck_en=1.
- bsr_so  in  1  serial out of the last boundary cell.
- tdo  out  1  test data out.
- tdo_en  out  1  high in Shift-IR/Shift-DR.
- bsr_si  out  1  serial in to the first boundary cell (= tdi).
- shift_dr  out  1  BSR shift select.
- capture_en  out  1  BSR capture strobe.
- update_en  out  1  BSR update strobe.
- mode  out  1  boundary cell output-mode select.
- tap_state  out  4  current TAP state encoding.
- ir_q  out  IR_WIDTH  current (updated) instruction.

Behaviour:
- States, 4-bit encoding:
  - TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauseDR=3, Ex2DR=0, UpdDR=5
  - SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauseIR=B, Ex2IR=8, UpdIR=D
- Transitions follow standard 1149.1 on tms, and are taken only in cycles with tck_en=1. With tck_en=0 all state and registers hold.
- rst=1 (any cycle, including mid-shift):
  - next clk: state=TLR, ir_q=OP_IDCODE, IR shift reg=0, bypass=0, ID shift reg=ID_VALUE.
  - tdo=0, tdo_en=0, shift_dr=0, capture_en=0, update_en=0, mode=0.
  - rst overrides tck_en.
- In TLR, ir_q is forced to OP_IDCODE every tck_en cycle.
- Five consecutive tck_en cycles with tms=1 reach TLR from any state.
- Register selection by ir_q:
  - EXTEST or SAMPLE → BSR.
  - IDCODE → ID register.
  - All-ones and all unlisted opcodes → bypass.
- CapIR: IR shift reg loads {zeros, 2'b01}.
- ShIR: IR shift reg shifts right, tdi into the MSB. tdo = IR shift reg bit0.
- UpdIR: ir_q ← IR shift reg, registered on the tck_en cycle that leaves UpdIR.
- CapDR: bypass←0; ID shift reg←ID_VALUE.
- ShDR: the selected register shifts right, tdi in at MSB; tdo = its bit0. For BSR, tdo = bsr_so.
- Outside shift states, tdo=0 and tdo_en=0.
- BSR controls are combinational from registered state, and nonzero only when BSR is selected:
  - shift_dr = (state==ShDR).
  - capture_en = tck_en & (state==CapDR): single-cycle pulse.
  - update_en = tck_en & (state==UpdDR): single-cycle pulse.
  - The BSR shifts when shift_dr & tck_en.
- mode = (ir_q==OP_EXTEST). It changes only on the UpdIR exit cycle, or on rst/TLR.
- Pause states: registers hold, tdo_en=0.
- Latency: state/register update is visible one clk after the qualifying tck_en cycle.
- Simultaneous tck_en and rst: reset wins.
- An IR load of an unknown opcode selects bypass with mode=0.

Test Plan:
- rst=1 for 2 clk, then 5×(tms=1, tck_en) → tap_state=F, ir_q=4'b0010, mode=0, all strobes 0.
- From TLR, tms sequence 0,1,0,0 then 32 ShDR shifts with tdi=0 → tdo serial stream LSB-first = 32'h1000_0ADB.
- Load IR 4'b0000 (tms 0,1,1,0,0, shift 4 bits, exit, update):
  - mode rises exactly 1 clk after the UpdIR tck_en.
  - ShIR tdo stream starts 1,0,0,0.
- With EXTEST selected, run CapDR→ShDR×8→UpdDR:
  - capture_en high exactly 1 cycle.
  - shift_dr high 8 tck_en cycles; tdo mirrors bsr_so.
  - update_en 1 pulse.
- Bypass (IR=4'b1111): shift tdi=1,0,1,1 through ShDR → tdo = 0,1,0,1 (1-bit delay); shift_dr stays 0.
- Assert rst during ShDR with tck_en=1 in the same cycle → next clk tap_state=F, tdo_en=0, ir_q=4'b0010; tck_en held 0 for 10 clk freezes tap_state.
